// File: rtl/adpll_seq.sv
// adpll_seq : lock sequencer between the radio MAC and the ADPLL core.
//
// Takes channel/mode requests from the MAC over a valid/ready handshake and
// drives the core through reset, enable and lock acquisition. Acquisition
// has a timeout and a bounded number of retries. Lock is confirmed and then
// monitored, and TX modulation data is held off until the loop has settled.
//
// Ports
//   clk, rst_n             reference clock, asynchronous active-low reset
//   req_valid / req_ready  request handshake (accepted when both high)
//   req_mode, req_fcw      requested mode (PD/TEST/RX/TX) and channel word
//   channel_lock           lock indication from the core
//   data_in                raw TX bit from the MAC
//   adpll_rst, adpll_en    core reset (active high) and enable
//   adpll_mode, fcw        mode and channel word presented to the core
//   data_mod               gated modulation bit to the core
//   locked                 high while in LOCKED
//   lock_lost              one-cycle pulse when lock is lost in LOCKED
//   err_timeout            sticky failure flag, cleared by the next request
//   state                  current sequencer state, for debug
module adpll_seq #(
    parameter int FCWW          = 26,
    parameter int RST_CYC       = 2,
    parameter int LOCK_CONFIRM  = 4,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int MAX_RETRY     = 3,
    parameter int TX_SETTLE_CYC = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_mode,
    input  logic [FCWW-1:0] req_fcw,
    input  logic            channel_lock,
    input  logic            data_in,
    output logic            adpll_rst,
    output logic            adpll_en,
    output logic [1:0]      adpll_mode,
    output logic [FCWW-1:0] fcw,
    output logic            data_mod,
    output logic            locked,
    output logic            lock_lost,
    output logic            err_timeout,
    output logic [2:0]      state
);

    localparam int CONF_W = $clog2(LOCK_CONFIRM + 1);
    localparam int RTY_W  = $clog2(MAX_RETRY + 1);
    localparam int RST_W  = $clog2(RST_CYC + 1);
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int SET_W  = $clog2(TX_SETTLE_CYC + 1);
    localparam int CNT_W  = (TMO_W > RST_W) ? ((TMO_W > SET_W) ? TMO_W : SET_W)
                                            : ((RST_W > SET_W) ? RST_W : SET_W);

    localparam logic [1:0] MODE_PD   = 2'd0;
    localparam logic [1:0] MODE_TEST = 2'd1;
    localparam logic [1:0] MODE_TX   = 2'd3;

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_RESET   = 3'd1,
        S_ACQUIRE = 3'd2,
        S_SETTLE  = 3'd3,
        S_LOCKED  = 3'd4,
        S_TEST    = 3'd5,
        S_FAIL    = 3'd6
    } state_t;

    state_t             state_q;
    logic               lock_prev;
    logic [CONF_W-1:0]  run_cnt;
    logic [CONF_W-1:0]  run_next;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [RTY_W-1:0]   retry_cnt;
    logic               accept;
    logic               lock_hi_conf;
    logic               lock_lo_conf;

    assign state  = state_q;
    assign accept = req_valid && req_ready;

    // Length of the current run of equal channel_lock samples, including the
    // sample taken at this edge. A change of level restarts the run at one;
    // the count holds once it reaches the confirm threshold so that a long
    // steady level never wraps back below it.
    always_comb begin
        run_next = run_cnt;
        if (channel_lock != lock_prev) begin
            run_next = CONF_W'(1);
        end else if (run_cnt != CONF_W'(LOCK_CONFIRM)) begin
            run_next = run_cnt + CONF_W'(1);
        end
    end

    assign lock_hi_conf = channel_lock  && (run_next == CONF_W'(LOCK_CONFIRM));
    assign lock_lo_conf = !channel_lock && (run_next == CONF_W'(LOCK_CONFIRM));

    // Sequencer FSM. Every output is registered and updated on the same edge
    // as the state change it belongs to. An accepted request always wins,
    // which is what suppresses lock_lost when a request lands on the edge of
    // the final low sample in LOCKED. cyc_cnt is shared by RESET, ACQUIRE and
    // SETTLE and restarts at zero on entry to each. data_mod defaults to zero
    // and is only loaded on edges that leave the FSM in LOCKED with mode TX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            req_ready   <= 1'b1;
            adpll_rst   <= 1'b0;
            adpll_en    <= 1'b0;
            adpll_mode  <= MODE_PD;
            fcw         <= '0;
            data_mod    <= 1'b0;
            locked      <= 1'b0;
            lock_lost   <= 1'b0;
            err_timeout <= 1'b0;
            lock_prev   <= 1'b0;
            run_cnt     <= '0;
            cyc_cnt     <= '0;
            retry_cnt   <= '0;
        end else begin
            lock_prev <= channel_lock;
            run_cnt   <= run_next;
            lock_lost <= 1'b0;
            data_mod  <= 1'b0;
            if (accept) begin
                adpll_mode  <= req_mode;
                fcw         <= req_fcw;
                err_timeout <= 1'b0;
                retry_cnt   <= '0;
                locked      <= 1'b0;
                adpll_rst   <= 1'b0;
                cyc_cnt     <= '0;
                case (req_mode)
                    MODE_PD: begin
                        state_q   <= S_OFF;
                        adpll_en  <= 1'b0;
                        req_ready <= 1'b1;
                    end
                    MODE_TEST: begin
                        state_q   <= S_TEST;
                        adpll_en  <= 1'b1;
                        req_ready <= 1'b1;
                    end
                    default: begin
                        state_q   <= S_RESET;
                        adpll_rst <= 1'b1;
                        adpll_en  <= 1'b0;
                        req_ready <= 1'b0;
                    end
                endcase
            end else begin
                case (state_q)
                    S_RESET: begin
                        if (cyc_cnt == CNT_W'(RST_CYC - 1)) begin
                            state_q   <= S_ACQUIRE;
                            adpll_rst <= 1'b0;
                            adpll_en  <= 1'b1;
                            cyc_cnt   <= '0;
                        end else begin
                            cyc_cnt <= cyc_cnt + CNT_W'(1);
                        end
                    end
                    S_ACQUIRE: begin
                        if (lock_hi_conf) begin
                            cyc_cnt <= '0;
                            if (adpll_mode == MODE_TX) begin
                                state_q <= S_SETTLE;
                            end else begin
                                state_q   <= S_LOCKED;
                                locked    <= 1'b1;
                                req_ready <= 1'b1;
                                retry_cnt <= '0;
                            end
                        end else if (cyc_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                            cyc_cnt   <= '0;
                            retry_cnt <= retry_cnt + RTY_W'(1);
                            if (int'(retry_cnt) + 1 < MAX_RETRY) begin
                                state_q   <= S_RESET;
                                adpll_rst <= 1'b1;
                                adpll_en  <= 1'b0;
                            end else begin
                                state_q     <= S_FAIL;
                                adpll_en    <= 1'b0;
                                err_timeout <= 1'b1;
                                req_ready   <= 1'b1;
                            end
                        end else begin
                            cyc_cnt <= cyc_cnt + CNT_W'(1);
                        end
                    end
                    S_SETTLE: begin
                        if (lock_lo_conf) begin
                            state_q <= S_ACQUIRE;
                            cyc_cnt <= '0;
                        end else if (cyc_cnt == CNT_W'(TX_SETTLE_CYC - 1)) begin
                            state_q   <= S_LOCKED;
                            locked    <= 1'b1;
                            req_ready <= 1'b1;
                            retry_cnt <= '0;
                            data_mod  <= data_in;
                        end else begin
                            cyc_cnt <= cyc_cnt + CNT_W'(1);
                        end
                    end
                    S_LOCKED: begin
                        if (lock_lo_conf) begin
                            state_q   <= S_ACQUIRE;
                            locked    <= 1'b0;
                            lock_lost <= 1'b1;
                            req_ready <= 1'b0;
                            cyc_cnt   <= '0;
                        end else begin
                            data_mod <= (adpll_mode == MODE_TX) ? data_in : 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adpll_seq.sv
// tb_adpll_seq : self-checking bench for adpll_seq.
//
// A behavioural model tracks the sequencer with absolute time stamps and an
// unbounded lock-run length and is compared with every DUT output after each
// clock edge. A table of request scenarios with hand-derived latencies and end
// states is applied in a loop, followed by hand-written lock-loss, gating,
// simultaneity and asynchronous-reset sequences and a randomised phase.
module tb_adpll_seq;

    localparam int FCWW          = 26;
    localparam int RST_CYC       = 2;
    localparam int LOCK_CONFIRM  = 4;
    localparam int LOCK_TIMEOUT  = 1024;
    localparam int MAX_RETRY     = 3;
    localparam int TX_SETTLE_CYC = 32;

    localparam int ST_OFF = 0, ST_RESET = 1, ST_ACQ = 2, ST_SETTLE = 3;
    localparam int ST_LOCKED = 4, ST_TEST = 5, ST_FAIL = 6;

    typedef logic [63:0] word_t;
    localparam word_t RESET_VEC = 64'd1 << 37;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic [1:0]      req_mode = 2'd0;
    logic [FCWW-1:0] req_fcw = '0;
    logic            channel_lock = 1'b0;
    logic            data_in = 1'b0;
    logic            req_ready, adpll_rst, adpll_en;
    logic [1:0]      adpll_mode;
    logic [FCWW-1:0] fcw;
    logic            data_mod, locked, lock_lost, err_timeout;
    logic [2:0]      state;

    int checks = 0;
    int failures = 0;

    int              now, t_enter, run, attempts, m_state;
    logic            prev_lock, m_lost, m_dmod, m_accept;
    logic [1:0]      m_mode;
    logic [FCWW-1:0] m_fcw;

    typedef struct {
        logic [1:0]      mode;
        logic [FCWW-1:0] fcw;
        int              lock_after;
        int              exp_lat;
        logic [2:0]      exp_state;
        logic            exp_locked;
        logic            exp_en;
        logic            exp_err;
    } vec_t;

    vec_t vecs[7];

    adpll_seq #(
        .FCWW(FCWW), .RST_CYC(RST_CYC), .LOCK_CONFIRM(LOCK_CONFIRM),
        .LOCK_TIMEOUT(LOCK_TIMEOUT), .MAX_RETRY(MAX_RETRY), .TX_SETTLE_CYC(TX_SETTLE_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_fcw(req_fcw), .channel_lock(channel_lock),
        .data_in(data_in), .adpll_rst(adpll_rst), .adpll_en(adpll_en),
        .adpll_mode(adpll_mode), .fcw(fcw), .data_mod(data_mod), .locked(locked),
        .lock_lost(lock_lost), .err_timeout(err_timeout), .state(state)
    );

    // 32 MHz reference, modelled with a 10 time-unit period.
    always #5 clk = ~clk;

    function automatic logic isReady(input int s);
        return (s == ST_OFF) || (s == ST_LOCKED) || (s == ST_TEST) || (s == ST_FAIL);
    endfunction

    function automatic word_t dutVec();
        return {26'd0, req_ready, adpll_rst, adpll_en, adpll_mode, fcw,
                data_mod, locked, lock_lost, err_timeout, state};
    endfunction

    function automatic word_t modelVec();
        logic en;
        en = (m_state == ST_ACQ) || (m_state == ST_SETTLE) || (m_state == ST_LOCKED) || (m_state == ST_TEST);
        return {26'd0, isReady(m_state), m_state == ST_RESET, en, m_mode, m_fcw,
                m_dmod, m_state == ST_LOCKED, m_lost, m_state == ST_FAIL, 3'(m_state)};
    endfunction

    task automatic checkOutput(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [FCWW-1:0] f,
                                 input logic l, input logic d);
        req_valid    = v;
        req_mode     = m;
        req_fcw      = f;
        channel_lock = l;
        data_in      = d;
    endtask

    task automatic modelReset();
        m_state   = ST_OFF;
        m_mode    = 2'd0;
        m_fcw     = '0;
        m_lost    = 1'b0;
        m_dmod    = 1'b0;
        m_accept  = 1'b0;
        run       = 0;
        prev_lock = 1'b0;
        attempts  = 0;
        t_enter   = now;
    endtask

    task automatic enterState(input int s);
        m_state = s;
        t_enter = now;
    endtask

    // Reference behaviour for one clock edge, using the inputs as they stand
    // at the edge. Time in a state is measured from the edge that entered it.
    task automatic modelStep();
        logic hi, lo;
        int   el;
        now++;
        if (!rst_n) begin
            modelReset();
        end else begin
            m_accept = 1'b0;
            m_lost   = 1'b0;
            run       = (channel_lock == prev_lock) ? run + 1 : 1;
            prev_lock = channel_lock;
            hi = channel_lock  && (run >= LOCK_CONFIRM);
            lo = !channel_lock && (run >= LOCK_CONFIRM);
            el = now - t_enter;
            if (req_valid && isReady(m_state)) begin
                m_accept = 1'b1;
                m_mode   = req_mode;
                m_fcw    = req_fcw;
                attempts = 0;
                if (req_mode == 2'd0)      enterState(ST_OFF);
                else if (req_mode == 2'd1) enterState(ST_TEST);
                else                       enterState(ST_RESET);
            end else if (m_state == ST_RESET) begin
                if (el == RST_CYC) enterState(ST_ACQ);
            end else if (m_state == ST_ACQ) begin
                if (hi) begin
                    enterState((m_mode == 2'd3) ? ST_SETTLE : ST_LOCKED);
                end else if (el == LOCK_TIMEOUT) begin
                    attempts++;
                    enterState((attempts < MAX_RETRY) ? ST_RESET : ST_FAIL);
                end
            end else if (m_state == ST_SETTLE) begin
                if (lo) enterState(ST_ACQ);
                else if (el == TX_SETTLE_CYC) enterState(ST_LOCKED);
            end else if (m_state == ST_LOCKED) begin
                if (lo) begin
                    m_lost = 1'b1;
                    enterState(ST_ACQ);
                end
            end
            if (m_state == ST_LOCKED) attempts = 0;
            m_dmod = (m_state == ST_LOCKED && m_mode == 2'd3) ? data_in : 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput($sformatf("cycle%0d", now), dutVec(), modelVec());
    endtask

    // Main sequence: reset, scenario table, hand-written corner cases and a
    // randomised run, all driven from negedges while tick() keeps the model
    // in step with the DUT.
    initial begin
        int   lat;
        int   lock_left;
        logic lock_lvl;
        logic drv;

        vecs[0] = '{2'd2, 26'd40632320,  102,  106, 3'd4, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{2'd3, 26'd39354368,   50,   86, 3'd4, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{2'd1, 26'd39976960,   -1,    0, 3'd5, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{2'd0, 26'd0,          -1,    0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{2'd2, 26'd39976960, 1022, 1026, 3'd4, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{2'd2, 26'd40632320,   -1, 3078, 3'd6, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{2'd3, 26'd40632320,  102,  138, 3'd4, 1'b1, 1'b1, 1'b0};

        now = 0;
        modelReset();
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("reset_outputs", dutVec(), RESET_VEC);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, vecs[i].mode, vecs[i].fcw, 1'b0, 1'b0);
            tick();
            applyStimulus(1'b0, vecs[i].mode, vecs[i].fcw, 1'b0, 1'b0);
            lat = -1;
            for (int k = 0; k < 4000; k++) begin
                if (req_ready) begin
                    lat = k;
                    break;
                end
                if (k == vecs[i].lock_after) channel_lock = 1'b1;
                tick();
            end
            checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            checkOutput($sformatf("vec%0d_state", i), 64'(state), 64'(vecs[i].exp_state));
            checkOutput($sformatf("vec%0d_locked", i), 64'(locked), 64'(vecs[i].exp_locked));
            checkOutput($sformatf("vec%0d_en", i), 64'(adpll_en), 64'(vecs[i].exp_en));
            checkOutput($sformatf("vec%0d_err", i), 64'(err_timeout), 64'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d_fcw", i), 64'(fcw), 64'(vecs[i].fcw));
            checkOutput($sformatf("vec%0d_mode", i), 64'(adpll_mode), 64'(vecs[i].mode));
        end

        channel_lock = 1'b0;
        repeat (3) tick();
        channel_lock = 1'b1;
        tick();
        checkOutput("glitch3_locked", 64'(locked), 64'(1));
        checkOutput("glitch3_state", 64'(state), 64'(ST_LOCKED));
        channel_lock = 1'b0;
        repeat (4) tick();
        checkOutput("loss_pulse", 64'(lock_lost), 64'(1));
        checkOutput("loss_locked", 64'(locked), 64'(0));
        checkOutput("loss_state", 64'(state), 64'(ST_ACQ));
        tick();
        checkOutput("loss_pulse_width", 64'(lock_lost), 64'(0));
        channel_lock = 1'b1;
        repeat (4) tick();
        checkOutput("relock_settle", 64'(state), 64'(ST_SETTLE));
        drv = 1'b0;
        for (int j = 1; j <= TX_SETTLE_CYC; j++) begin
            drv = ~drv;
            data_in = drv;
            tick();
            checkOutput($sformatf("settle_gate%0d", j), 64'(data_mod), 64'((j == TX_SETTLE_CYC) ? drv : 1'b0));
        end
        checkOutput("relock_locked", 64'(state), 64'(ST_LOCKED));
        for (int j = 0; j < 8; j++) begin
            drv = ~drv;
            data_in = drv;
            tick();
            checkOutput($sformatf("tx_lag%0d", j), 64'(data_mod), 64'(drv));
        end
        applyStimulus(1'b1, 2'd0, '0, 1'b1, ~drv);
        tick();
        req_valid = 1'b0;
        checkOutput("pd_data_mod", 64'(data_mod), 64'(0));
        checkOutput("pd_en", 64'(adpll_en), 64'(0));
        checkOutput("pd_state", 64'(state), 64'(ST_OFF));

        applyStimulus(1'b1, 2'd2, 26'd40632320, 1'b0, 1'b0);
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        channel_lock = 1'b1;
        repeat (4) tick();
        checkOutput("rx_lock_state", 64'(state), 64'(ST_LOCKED));
        channel_lock = 1'b0;
        repeat (3) tick();
        applyStimulus(1'b1, 2'd2, 26'd39354368, 1'b0, 1'b0);
        tick();
        req_valid = 1'b0;
        checkOutput("simul_no_lost", 64'(lock_lost), 64'(0));
        checkOutput("simul_state", 64'(state), 64'(ST_RESET));
        checkOutput("simul_fcw", 64'(fcw), 64'(26'd39354368));
        repeat (2) tick();
        applyStimulus(1'b1, 2'd1, 26'd39976960, 1'b0, 1'b0);
        repeat (10) tick();
        checkOutput("held_state", 64'(state), 64'(ST_ACQ));
        checkOutput("held_mode", 64'(adpll_mode), 64'(2));
        channel_lock = 1'b1;
        repeat (4) tick();
        checkOutput("held_locked_first", 64'(state), 64'(ST_LOCKED));
        tick();
        req_valid = 1'b0;
        checkOutput("held_taken", 64'(state), 64'(ST_TEST));
        checkOutput("held_fcw", 64'(fcw), 64'(26'd39976960));

        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", dutVec(), RESET_VEC);
        tick();
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        lock_left = 0;
        lock_lvl  = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (lock_left == 0) begin
                lock_lvl = ($urandom_range(0, 3) != 0);
                if (lock_lvl)                          lock_left = $urandom_range(1, 200);
                else if ($urandom_range(0, 15) == 0)   lock_left = $urandom_range(1100, 1500);
                else                                   lock_left = $urandom_range(1, 8);
            end
            lock_left--;
            if (m_accept) req_valid = 1'b0;
            if (!req_valid && $urandom_range(0, 49) == 0) begin
                req_valid = 1'b1;
                req_mode  = 2'($urandom_range(0, 3));
                req_fcw   = FCWW'($urandom);
            end
            channel_lock = lock_lvl;
            data_in      = 1'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adpll_seq.md
# adpll_seq

ADPLL lock sequencer sitting between the radio MAC and the `adpll_ctr0` core. Accepts channel/mode requests over a valid/ready handshake, then drives the core's `rst`, `en`, `adpll_mode` and `FCW` in order: reset pulse, enable, lock acquisition with timeout and retry. It confirms and monitors `channel_lock`, and gates TX modulation data until the loop has settled. Reports lock, lock-loss and failure status to the MAC.

## Interface
- `FCWW`, 26, FCW width (MHz × 16384 format)
- `RST_CYC`, 2, cycles `adpll_rst` is held high per acquisition attempt
- `LOCK_CONFIRM`, 4, consecutive equal `channel_lock` samples needed to declare lock or lock loss
- `LOCK_TIMEOUT`, 1024, ACQUIRE cycles allowed per attempt (32 µs at 32 MHz)
- `MAX_RETRY`, 3, acquisition attempts before FAIL
- `TX_SETTLE_CYC`, 32, post-lock settle cycles in TX before modulation is released
- `clk` in 1: 32 MHz reference clock
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid` in 1 / `req_ready` out 1: request handshake; accepted on the `clk` edge where both are high
- `req_mode` in 2: PD=0, TEST=1, RX=2, TX=3
- `req_fcw` in FCWW: channel word
- `channel_lock` in 1: lock indication from the core
- `data_in` in 1: raw TX bit from the MAC
- `adpll_rst` out 1: active-high reset to the core
- `adpll_en` out 1: core enable
- `adpll_mode` out 2: core mode
- `fcw` out FCWW: core FCW
- `data_mod` out 1: gated modulation bit to the core
- `locked` out 1: high in LOCKED
- `lock_lost` out 1: one-cycle pulse on detected loss of lock
- `err_timeout` out 1: sticky failure flag
- `state` out 3: current state, for debug

## Operation
- States: OFF=0, RESET=1, ACQUIRE=2, SETTLE=3, LOCKED=4, TEST=5, FAIL=6.
- `req_ready`=1 in OFF, LOCKED, TEST and FAIL; 0 in all other states. Requests presented while `req_ready`=0 are held by the MAC, not dropped.
- On acceptance:
  - latch `req_mode` → `adpll_mode` and `req_fcw` → `fcw`
  - clear `err_timeout` and the retry count
  - PD → OFF; TEST → TEST; RX/TX → RESET
- OFF: `adpll_en`=0, `adpll_rst`=0, `adpll_mode`=PD.
- TEST: `adpll_en`=1. No lock monitoring; `locked`=0.
- RESET: `adpll_rst`=1, `adpll_en`=0 for RST_CYC cycles, then → ACQUIRE.
- ACQUIRE: `adpll_rst`=0, `adpll_en`=1.
  - Cycle counter starts at 0 on entry.
  - Lock confirmed: LOCK_CONFIRM consecutive high `channel_lock` samples → SETTLE if TX, LOCKED if RX.
  - Timeout: counter reaches LOCK_TIMEOUT−1 unconfirmed → increment retry. retry<MAX_RETRY → RESET; otherwise → FAIL.
- SETTLE: counts TX_SETTLE_CYC cycles → LOCKED. A `channel_lock` loss (LOCK_CONFIRM consecutive low samples) → ACQUIRE.
- LOCKED:
  - `locked`=1; retry count cleared on entry.
  - LOCK_CONFIRM consecutive low samples → `lock_lost` pulse, → ACQUIRE (counts as a new attempt).
- FAIL: `adpll_en`=0, `err_timeout`=1 until the next accepted request.
- `data_mod` = `data_in` registered when state=LOCKED and mode=TX; 0 otherwise.
- Priority: in LOCKED, an accepted request overrides a simultaneous lock-loss detection (no `lock_lost` pulse).
- Counters saturate-free: sized ceil(log2(param+1)); confirm counter resets whenever `channel_lock` changes.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - state=OFF, `req_ready`=1
  - `adpll_rst`=0, `adpll_en`=0, `adpll_mode`=0, `fcw`=0
  - `data_mod`=0, `locked`=0, `lock_lost`=0, `err_timeout`=0
- Reset mid-operation aborts everything; no handshake is completed.
- All outputs are registered.
- Request accepted at edge N:
  - `fcw`/`adpll_mode` valid and `req_ready`=0 from N+1
  - `adpll_rst`=1 during cycles N+1..N+RST_CYC
  - `adpll_en`=1 from N+RST_CYC+1
- Lock: the LOCK_CONFIRM-th consecutive high sample at edge M → `locked`=1 from M+1 (RX); TX → `locked`=1 from M+TX_SETTLE_CYC+1.
- `data_mod` lags `data_in` by one cycle when enabled.
- `lock_lost` high for exactly one cycle, coincident with the first ACQUIRE cycle.

## Test plan
- Reset: assert `rst_n`=0 mid-clock → all outputs at reset values immediately, `state`=0.
- RX lock: request RX, `fcw`=40632320 (2480 MHz); `channel_lock` rises 100 cycles into ACQUIRE → `adpll_rst` high exactly 2 cycles, `locked`=1 4 cycles after lock rises, `req_ready`=1 with it.
- TX gating: same as RX with mode TX and `data_in` toggling every cycle → `data_mod`=0 until 32 cycles after confirmation, then follows `data_in` with 1-cycle lag; a PD request → `data_mod`=0 and `adpll_en`=0 next cycle.
- Timeout: `channel_lock` held 0 → 3 `adpll_rst` pulses, FAIL after 3×(2+1024) cycles; `err_timeout`=1, `adpll_en`=0; a new request clears `err_timeout`.
- Lock loss: in LOCKED, drop `channel_lock` for 3 cycles → no change; drop it for 4 cycles → one `lock_lost` pulse, `locked`=0, ACQUIRE entered; relock → LOCKED.
- Simultaneity: a valid request on the same edge as the 4th low sample in LOCKED → request taken, no `lock_lost`; a request held during ACQUIRE is accepted only after LOCKED is reached.
